ring_stop_arb: RTL and testbench
================================

// Module: ring_stop_arb
// PURPOSE
//  Ring-stop output stage. Merges two TwoRegFifo-style sources into one registered
//  ring link: through-traffic (upstream ring) and local injection. Writes into the
//  next hop's two-register FIFO. Through-traffic has priority; a starvation counter
//  guarantees local injection a slot. Bandwidth is one flit per cycle when unstalled.
// PARAMETERS
//  WIDTH       32  flit width in bits
//  STARVE_MAX  8   max consecutive contested thr grants before local is forced (>=1)
// PORTS
//  clk           in   1      clock
//  rst           in   1      reset, asynchronous, active-low
//  iThrNotEmpty  in   1      through FIFO holds a flit
//  iThrDat       in   WIDTH  through FIFO head flit
//  oThrRdEn      out  1      pop through FIFO this cycle
//  iLocNotEmpty  in   1      local inject FIFO holds a flit
//  iLocDat       in   WIDTH  local FIFO head flit
//  oLocRdEn      out  1      pop local FIFO this cycle
//  iDnFul        in   1      downstream FIFO full (its oFul)
//  oDnWrEn       out  1      write flit into downstream FIFO
//  oDnWrDat      out  WIDTH  flit to downstream FIFO
//  oLocGnt       out  1      registered: flit in output reg came from local source
// BEHAVIOUR
//  - Single clock domain. Reset is asynchronous and active-low: rst low clears
//    outVld, outDat, oLocGnt and starveCnt to 0 immediately, independent of clk.
//  - Output register {outVld, outDat}. oDnWrEn = outVld & !iDnFul. oDnWrDat = outDat.
//  - Never write while iDnFul=1. The downstream FIFO drops writes when full, and
//    also when full and read in the same cycle.
//  - load = !outVld | !iDnFul. The register refills in the same cycle it drains.
//  - Grant, evaluated only when load=1:
//    - thr only non-empty: grant thr.
//    - loc only non-empty: grant loc.
//    - both non-empty: grant loc if starveCnt==STARVE_MAX, otherwise grant thr.
//    - neither: no grant; outVld<=0 if load.
//  - oThrRdEn = load & grantThr. oLocRdEn = load & grantLoc.
//    - These are combinational, mutually exclusive and never 1 when the source is empty.
//  - On grant: outDat <= granted dat; outVld <= 1; oLocGnt <= grantLoc.
//  - On load without grant: outDat holds its value.
//  - starveCnt is $clog2(STARVE_MAX+1) bits wide:
//    - load & both non-empty & thr granted: +1, saturating at STARVE_MAX.
//    - load & loc granted, or iLocNotEmpty=0: clear to 0.
//    - otherwise (including load=0 stall cycles): hold.
//  - Latency: a source pop in cycle N gives oDnWrEn in N+1, if iDnFul=0.
//  - Stall: while outVld & iDnFul, hold outDat/oLocGnt/starveCnt; no rd enables.
//  - Reset mid-operation: any flit held in the output register is discarded, with no
//    write. Source FIFOs are not popped during or after reset until load & non-empty.
//  - iDnFul may be X when outVld=0; the design must not propagate it.
// TESTING
//  1 Reset: outVld=1, iDnFul=1, drop rst between edges -> oDnWrEn=0 at once;
//    after release oLocGnt=0 and starveCnt=0.
//  2 Thr stream: thr FIFO holds A=0x11, B=0x22, iDnFul=0 -> oThrRdEn in cycles 0,1;
//    oDnWrEn with 0x11 in cycle 1 and 0x22 in cycle 2; no loc pop.
//  3 Backpressure: outDat=0x33 valid, iDnFul=1 for 3 cycles -> oDnWrEn=0, no pops,
//    data held; iDnFul=0 -> 0x33 written and next thr flit popped the same cycle.
//  4 Starvation, STARVE_MAX=8: both sources always non-empty, iDnFul=0 -> 8 thr pops
//    then 1 loc pop (oLocGnt=1 the next cycle); 9-cycle pattern repeats.
//  5 Loc alone: thr empty, loc holds 3 flits -> 3 consecutive loc pops; starveCnt stays 0.
//    Thr flit arriving next wins at once.
//  6 Throughput/random: random non-empty/iDnFul -> 1 flit/cycle when free; a scoreboard
//    shows no loss, duplication or reorder per source; no write while iDnFul=1.

Source files
------------

// File: rtl/ring_stop_arb.sv
// ---------------------------------------------------------------------------
// ring_stop_arb
//
// Output stage of a ring stop. Two two-register FIFO sources are merged into
// one registered ring link that writes into the next hop's FIFO:
//   - through traffic (upstream ring) has priority,
//   - local injection is forced through after STARVE_MAX consecutive
//     contested through grants, so it can never be starved.
// Sustains one flit per cycle while downstream is not full.
//
// Handshake: a source flit is consumed in the cycle its rd enable is high.
// A rd enable is only raised while that source reports not-empty. The
// downstream FIFO accepts a flit in the cycle oDnWrEn is high, and oDnWrEn is
// never high while iDnFul is high.
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active low
//   iThrNotEmpty  through FIFO holds a flit
//   iThrDat       through FIFO head flit
//   oThrRdEn      pop through FIFO this cycle
//   iLocNotEmpty  local inject FIFO holds a flit
//   iLocDat       local FIFO head flit
//   oLocRdEn      pop local FIFO this cycle
//   iDnFul        downstream FIFO full
//   oDnWrEn       write flit into downstream FIFO
//   oDnWrDat      flit to downstream FIFO
//   oLocGnt       flit in the output register came from the local source
// ---------------------------------------------------------------------------
module ring_stop_arb #(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iThrNotEmpty,
    input  logic [WIDTH-1:0] iThrDat,
    output logic             oThrRdEn,
    input  logic             iLocNotEmpty,
    input  logic [WIDTH-1:0] iLocDat,
    output logic             oLocRdEn,
    input  logic             iDnFul,
    output logic             oDnWrEn,
    output logic [WIDTH-1:0] oDnWrDat,
    output logic             oLocGnt
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_dat_q, out_dat_d;
    logic             loc_gnt_q, loc_gnt_d;
    logic [CW-1:0]    starve_cnt_q, starve_cnt_d;

    logic load;
    logic both;
    logic grant_thr;
    logic grant_loc;

    // iDnFul is only looked at while the output register is valid, so an
    // unknown full flag from an idle link cannot leak into the datapath.
    always_comb begin
        load      = out_vld_q ? !iDnFul : 1'b1;
        both      = iThrNotEmpty && iLocNotEmpty;
        grant_loc = iLocNotEmpty && (!iThrNotEmpty || (starve_cnt_q == STARVE_LIM));
        grant_thr = iThrNotEmpty && !grant_loc;
    end

    // Pops are suppressed while reset is asserted: the register cannot
    // capture a flit then, so popping would lose it.
    assign oThrRdEn = rst && load && grant_thr;
    assign oLocRdEn = rst && load && grant_loc;
    assign oDnWrEn  = out_vld_q ? !iDnFul : 1'b0;
    assign oDnWrDat = out_dat_q;
    assign oLocGnt  = loc_gnt_q;

    always_comb begin
        out_vld_d    = out_vld_q;
        out_dat_d    = out_dat_q;
        loc_gnt_d    = loc_gnt_q;
        starve_cnt_d = starve_cnt_q;

        if (load) begin
            if (grant_thr || grant_loc) begin
                out_vld_d = 1'b1;
                out_dat_d = grant_loc ? iLocDat : iThrDat;
                loc_gnt_d = grant_loc;
            end else begin
                // Register drains with nothing to refill it; data is kept.
                out_vld_d = 1'b0;
            end
        end

        // Starvation counts only contested through grants; it restarts
        // whenever local gets a slot or has nothing to send.
        if (!iLocNotEmpty) begin
            starve_cnt_d = '0;
        end else if (load && grant_loc) begin
            starve_cnt_d = '0;
        end else if (load && both && grant_thr && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld_q    <= 1'b0;
            out_dat_q    <= '0;
            loc_gnt_q    <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            out_vld_q    <= out_vld_d;
            out_dat_q    <= out_dat_d;
            loc_gnt_q    <= loc_gnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_ring_stop_arb.sv
// Bench for ring_stop_arb: directed scenarios with literal expectations,
// a per-cycle behavioural model of the link, and a scoreboard of popped
// flits that must appear on the downstream link in pop order.
module tb_ring_stop_arb;
  localparam int W    = 32;
  localparam int SMAX = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic         thr_ne;
  logic [W-1:0] thr_dat;
  logic         thr_rd;
  logic         loc_ne;
  logic [W-1:0] loc_dat;
  logic         loc_rd;
  logic         dn_ful;
  logic         wr_en;
  logic [W-1:0] wr_dat;
  logic         loc_gnt;

  ring_stop_arb #(.WIDTH(W), .STARVE_MAX(SMAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .iThrNotEmpty (thr_ne),
    .iThrDat      (thr_dat),
    .oThrRdEn     (thr_rd),
    .iLocNotEmpty (loc_ne),
    .iLocDat      (loc_dat),
    .oLocRdEn     (loc_rd),
    .iDnFul       (dn_ful),
    .oDnWrEn      (wr_en),
    .oDnWrDat     (wr_dat),
    .oLocGnt      (loc_gnt)
  );

  // ---------------- environment / model state ----------------
  logic [W-1:0] thr_fifo[$];
  logic [W-1:0] loc_fifo[$];
  logic [W:0]   exp_q[$];      // {from_local, flit} in pop order

  int n_checks = 0;
  int n_pass   = 0;

  // Link model: what the output register must hold, by the stated rules.
  logic         m_vld;
  logic         m_loc;
  logic [W-1:0] m_dat;
  int           m_starve;

  // Outputs captured in the last step, for directed literal checks.
  logic         s_thr_rd, s_loc_rd, s_wr, s_gnt;
  logic [W-1:0] s_wr_dat;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_vld    = 1'b0;
    m_loc    = 1'b0;
    m_dat    = '0;
    m_starve = 0;
    exp_q.delete();
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called just after a rising edge; leaves just after the next one.
  task automatic step(input logic full);
    logic       can_load;
    logic       e_wr;
    int         pick;     // 0 none, 1 through, 2 local
    logic [W:0] head;
    logic       cap_thr, cap_loc;

    dn_ful  = full;
    thr_ne  = (thr_fifo.size() > 0);
    thr_dat = thr_ne ? thr_fifo[0] : 32'hdead_0001;
    loc_ne  = (loc_fifo.size() > 0);
    loc_dat = loc_ne ? loc_fifo[0] : 32'hdead_0002;

    e_wr     = m_vld ? (full == 1'b0) : 1'b0;
    can_load = m_vld ? (full == 1'b0) : 1'b1;
    pick = 0;
    if (can_load) begin
      if (thr_ne && loc_ne) pick = (m_starve == SMAX) ? 2 : 1;
      else if (thr_ne)      pick = 1;
      else if (loc_ne)      pick = 2;
    end

    @(negedge clk);
    check("thr_rd",  thr_rd,  pick == 1);
    check("loc_rd",  loc_rd,  pick == 2);
    check("wr_en",   wr_en,   e_wr);
    check("loc_gnt", loc_gnt, m_loc);
    if (e_wr) check("wr_dat", wr_dat, m_dat);
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_spurious_write", 1, 0);
      end else begin
        head = exp_q.pop_front();
        check("sb_flit", wr_dat, head[W-1:0]);
        check("sb_source", loc_gnt, head[W]);
      end
    end
    s_thr_rd = thr_rd;
    s_loc_rd = loc_rd;
    s_wr     = wr_en;
    s_wr_dat = wr_dat;
    s_gnt    = loc_gnt;
    cap_thr  = (thr_rd === 1'b1);
    cap_loc  = (loc_rd === 1'b1);

    @(posedge clk);
    #1;
    // Environment FIFOs react to what the DUT actually popped.
    if (cap_thr && thr_fifo.size() > 0) exp_q.push_back({1'b0, thr_fifo.pop_front()});
    if (cap_loc && loc_fifo.size() > 0) exp_q.push_back({1'b1, loc_fifo.pop_front()});
    // Model advances by the rules.
    if (can_load) begin
      if (pick != 0) begin
        m_vld = 1'b1;
        m_dat = (pick == 2) ? loc_dat : thr_dat;
        m_loc = (pick == 2);
      end else begin
        m_vld = 1'b0;
      end
    end
    if (!loc_ne)                                   m_starve = 0;
    else if (can_load && pick == 2)                m_starve = 0;
    else if (can_load && thr_ne && m_starve < SMAX) m_starve++;
  endtask

  // ---------------- stimulus ----------------
  int seq;

  initial begin
    rst    = 1'b0;
    dn_ful = 1'b0;
    thr_ne = 1'b0; thr_dat = '0;
    loc_ne = 1'b0; loc_dat = '0;
    model_reset();
    seq = 0;

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check("por_wr_en",   wr_en,   1'b0);
    check("por_loc_gnt", loc_gnt, 1'b0);
    rst = 1'b1;

    // Through stream: 0x11 then 0x22, one cycle of latency.
    thr_fifo = '{32'h11, 32'h22};
    step(1'b0);
    check("thr_c0_pop", s_thr_rd, 1'b1);
    check("thr_c0_loc", s_loc_rd, 1'b0);
    check("thr_c0_wr",  s_wr,     1'b0);
    step(1'b0);
    check("thr_c1_pop", s_thr_rd, 1'b1);
    check("thr_c1_wr",  s_wr,     1'b1);
    check("thr_c1_dat", s_wr_dat, 32'h11);
    step(1'b0);
    check("thr_c2_wr",  s_wr,     1'b1);
    check("thr_c2_dat", s_wr_dat, 32'h22);
    check("thr_c2_pop", s_thr_rd, 1'b0);
    step(1'b0);
    check("thr_c3_idle", s_wr, 1'b0);

    // Backpressure: 0x33 held for three full cycles.
    thr_fifo = '{32'h33, 32'h44};
    step(1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check("bp_no_wr",  s_wr,     1'b0);
      check("bp_no_pop", s_thr_rd, 1'b0);
      check("bp_hold",   s_wr_dat, 32'h33);
    end
    step(1'b0);
    check("bp_rel_wr",  s_wr,     1'b1);
    check("bp_rel_dat", s_wr_dat, 32'h33);
    check("bp_rel_pop", s_thr_rd, 1'b1);
    step(1'b0);
    check("bp_next_dat", s_wr_dat, 32'h44);
    step(1'b0);

    // Reset in the middle of a stall with a valid flit in the register.
    thr_fifo = '{32'h01, 32'h02};
    loc_fifo = '{32'h8000_0055};
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check("pre_rst_starve", dut.starve_cnt_q, 2);
    #2;
    rst = 1'b0;
    #1;
    check("rst_wr_now", wr_en, 1'b0);
    dn_ful = 1'b0;
    thr_ne = 1'b0;
    loc_ne = 1'b1;
    loc_dat = 32'h8000_0055;
    #1;
    check("rst_wr_unfull", wr_en,  1'b0);
    check("rst_no_locpop", loc_rd, 1'b0);
    model_reset();           // held flit 0x02 is discarded
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_loc_gnt", loc_gnt, 1'b0);
    check("rst_starve",  dut.starve_cnt_q, 0);
    step(1'b0);
    check("post_rst_locpop", s_loc_rd, 1'b1);
    step(1'b0);
    check("post_rst_dat", s_wr_dat, 32'h8000_0055);
    step(1'b0);

    // Local alone: three back-to-back pops, starvation count stays 0.
    loc_fifo = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0003};
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      check("loc_only_pop", s_loc_rd, 1'b1);
      check("loc_only_starve", dut.starve_cnt_q, 0);
    end
    thr_fifo.push_back(32'h77);
    loc_fifo.push_back(32'h8000_0004);
    step(1'b0);
    check("thr_wins_thr", s_thr_rd, 1'b1);
    check("thr_wins_loc", s_loc_rd, 1'b0);
    repeat (3) step(1'b0);

    // Starvation: both always non-empty -> 8 through, 1 local, repeating.
    for (int i = 0; i < 18; i++) begin
      while (thr_fifo.size() < 2) begin thr_fifo.push_back(32'h100 + seq); seq++; end
      while (loc_fifo.size() < 2) begin loc_fifo.push_back(32'h8000_0100 + seq); seq++; end
      step(1'b0);
      check("starve_loc_pop", s_loc_rd, (i == 8) || (i == 17));
      check("starve_thr_pop", s_thr_rd, !((i == 8) || (i == 17)));
      if (i == 9) check("starve_loc_gnt", s_gnt, 1'b1);
    end
    thr_fifo.delete();
    loc_fifo.delete();
    repeat (2) step(1'b0);

    // Random traffic and backpressure; full is unknown when the link is idle.
    for (int i = 0; i < 400; i++) begin
      if (thr_fifo.size() < 2 && $urandom_range(0, 2) != 0) begin
        thr_fifo.push_back(32'h0001_0000 + seq); seq++;
      end
      if (loc_fifo.size() < 2 && $urandom_range(0, 2) == 0) begin
        loc_fifo.push_back(32'h8001_0000 + seq); seq++;
      end
      if (!m_vld && $urandom_range(0, 3) == 0) step(1'bx);
      else step($urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() != 0 || thr_fifo.size() != 0 || loc_fifo.size() != 0 || m_vld) step(1'b0);
    end
    check("drain_sb_empty", exp_q.size(), 0);
    check("drain_src_empty", thr_fifo.size() + loc_fifo.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
